// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: FSM state encoding,
// oversampling ratio and the default frame width.
package uart_pkg;

    localparam int OSR          = 16;
    localparam int DBIT_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_transmitter_if.sv
// Parallel write port of the UART transmitter (APB register side -> holding register).
interface uart_transmitter_if
    import uart_pkg::*;
#(
    parameter int DBIT = DBIT_DEFAULT
);
    // tx_start is a one-clock write strobe (valid) and tx_ready means the holding
    // register is empty (ready); a byte transfers on a clock where both are high
    // and the transmitter is enabled. A strobe while tx_ready=0 is discarded.
    logic [DBIT-1:0] din;
    logic            tx_start;
    logic            tx_ready;

    modport master (
        output din,
        output tx_start,
        input  tx_ready
    );

    modport slave (
        input  din,
        input  tx_start,
        output tx_ready
    );
endinterface

// File: rtl/uart_transmitter.sv
// 16x-oversampled UART serializer: one-entry holding register feeding a
// START/DATA/STOP shift FSM clocked by the shared s_tick strobe.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEFAULT,
    parameter int SB_TICK = 16
) (
    input  logic                clk,
    input  logic                PRESETn,
    input  logic                tx_en,
    input  logic                tx_rst,
    input  logic                s_tick,
    uart_transmitter_if.slave   bus,
    output logic                tx,
    output logic                tx_done_tick,
    output logic                tx_busy,
    output uart_state_e         dbg_state
);

    localparam int CW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [CW-1:0] OSR_LAST  = CW'(OSR - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

    uart_state_e     r_state, w_state;
    logic [DBIT-1:0] r_hold, w_hold;
    logic            r_hold_valid, w_hold_valid;
    logic [DBIT-1:0] r_shift, w_shift;
    logic [CW-1:0]   r_tick, w_tick;
    logic [BW-1:0]   r_bit, w_bit;
    logic            r_tx, w_tx;
    logic            r_done, w_done;
    logic            w_accept;
    logic            w_launch;

    assign w_accept = bus.tx_start & ~r_hold_valid & tx_en;

    always_comb begin
        w_state  = r_state;
        w_shift  = r_shift;
        w_tick   = r_tick;
        w_bit    = r_bit;
        w_tx     = r_tx;
        w_done   = 1'b0;
        w_launch = 1'b0;

        case (r_state)
            IDLE: begin
                if (r_hold_valid && tx_en) begin
                    w_launch = 1'b1;
                    w_state  = START;
                    w_shift  = r_hold;
                    w_tick   = '0;
                    w_tx     = 1'b0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_tick == OSR_LAST) begin
                        w_tick  = '0;
                        w_bit   = '0;
                        w_state = DATA;
                        w_tx    = r_shift[0];
                    end else begin
                        w_tick = r_tick + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_tick == OSR_LAST) begin
                        w_tick  = '0;
                        w_shift = r_shift >> 1;
                        if (r_bit == BIT_LAST) begin
                            w_state = STOP;
                            w_tx    = 1'b1;
                        end else begin
                            w_bit = r_bit + 1'b1;
                            w_tx  = w_shift[0];
                        end
                    end else begin
                        w_tick = r_tick + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (r_tick == STOP_LAST) begin
                        w_done = 1'b1;
                        w_tick = '0;
                        // A queued byte starts on this same edge: no idle gap between frames.
                        if (r_hold_valid && tx_en) begin
                            w_launch = 1'b1;
                            w_state  = START;
                            w_shift  = r_hold;
                            w_tx     = 1'b0;
                        end else begin
                            w_state = IDLE;
                        end
                    end else begin
                        w_tick = r_tick + 1'b1;
                    end
                end
            end
            default: begin
                w_state = IDLE;
                w_tx    = 1'b1;
            end
        endcase
    end

    // Launch needs a valid entry and accept needs an empty one, so they never coincide.
    always_comb begin
        w_hold       = r_hold;
        w_hold_valid = r_hold_valid;
        if (w_launch) begin
            w_hold_valid = 1'b0;
        end else if (w_accept) begin
            w_hold       = bus.din;
            w_hold_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!PRESETn || tx_rst) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_tick       <= '0;
            r_bit        <= '0;
            r_tx         <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_hold       <= w_hold;
            r_hold_valid <= w_hold_valid;
            r_shift      <= w_shift;
            r_tick       <= w_tick;
            r_bit        <= w_bit;
            r_tx         <= w_tx;
            r_done       <= w_done;
        end
    end

    assign bus.tx_ready = ~r_hold_valid;
    assign tx           = r_tx;
    assign tx_done_tick = r_done;
    assign tx_busy      = (r_state != IDLE);
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a line monitor decodes every frame on tx and
// checks it against bytes the stimulus expects to be sent.
module tb_uart_transmitter;
    import uart_pkg::*;

    localparam int DBIT     = 8;
    localparam int TICK_DIV = 4;
    localparam int FRAME1   = OSR + OSR * DBIT + 16;
    localparam int FRAME2   = OSR + OSR * DBIT + 32;

    // ---------------- clock / reset / tick ----------------
    logic clk     = 1'b0;
    logic PRESETn = 1'b0;
    logic tx_en   = 1'b0;
    logic tx_rst  = 1'b0;
    logic s_tick  = 1'b0;
    int   tick_div_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_div_cnt = (tick_div_cnt == TICK_DIV - 1) ? 0 : tick_div_cnt + 1;
        s_tick       = (tick_div_cnt == 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUTs ----------------
    logic        tx1, done1, busy1;
    logic        tx2, done2, busy2;
    uart_state_e st1, st2;

    uart_transmitter_if #(.DBIT(DBIT)) bus1 ();
    uart_transmitter_if #(.DBIT(DBIT)) bus2 ();

    uart_transmitter #(.DBIT(DBIT), .SB_TICK(16)) u_dut1 (
        .clk(clk), .PRESETn(PRESETn), .tx_en(tx_en), .tx_rst(tx_rst), .s_tick(s_tick),
        .bus(bus1.slave), .tx(tx1), .tx_done_tick(done1), .tx_busy(busy1), .dbg_state(st1)
    );

    uart_transmitter #(.DBIT(DBIT), .SB_TICK(32)) u_dut2 (
        .clk(clk), .PRESETn(PRESETn), .tx_en(tx_en), .tx_rst(1'b0), .s_tick(s_tick),
        .bus(bus2.slave), .tx(tx2), .tx_done_tick(done2), .tx_busy(busy2), .dbg_state(st2)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard / line monitor ----------------
    logic [DBIT-1:0] exp_q[$];
    int done_cnt  = 0;
    int abort_cnt = 0;
    int align_err = 0;

    initial begin : mon1
        logic [DBIT-1:0] data;
        int   tidx;
        logic prev;
        logic in_frame;
        @(posedge PRESETn);
        forever begin
            while (tx1 !== 1'b0) begin
                @(posedge clk); #1;
            end
            data     = '0;
            tidx     = 0;
            prev     = 1'b0;
            in_frame = 1'b1;
            while (in_frame) begin
                @(posedge clk); #1;
                if (s_tick) tidx++;
                if (done1) begin
                    check("frame_len", tidx, FRAME1);
                    if (exp_q.size() == 0) check("frame_expected", 32'(exp_q.size() != 0), 1);
                    else                   check("rx_byte", 32'(data), 32'(exp_q.pop_front()));
                    done_cnt++;
                    in_frame = 1'b0;
                end else if (!busy1) begin
                    abort_cnt++;
                    in_frame = 1'b0;
                end else begin
                    if (tx1 !== prev && !s_tick) align_err++;
                    if (s_tick && tidx == OSR / 2) check("start_bit", tx1, 0);
                    if (s_tick && tidx > OSR && tidx <= OSR * (DBIT + 1) && ((tidx - OSR) % OSR) == OSR / 2)
                        data[(tidx - OSR) / OSR] = tx1;
                    if (s_tick && tidx == OSR * (DBIT + 1) + OSR / 2) check("stop_bit", tx1, 1);
                end
                prev = tx1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send1(input logic [DBIT-1:0] b, input logic accept_exp);
        @(negedge clk);
        bus1.din      = b;
        bus1.tx_start = 1'b1;
        @(posedge clk); #1;
        bus1.tx_start = 1'b0;
        if (accept_exp) exp_q.push_back(b);
    endtask

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge clk); #1;
            if (s_tick) c++;
        end
    endtask

    task automatic wait_idle1(input int budget);
        int c = 0;
        while ((busy1 !== 1'b0 || bus1.tx_ready !== 1'b1) && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= budget) check("idle_timeout", busy1, 0);
        @(posedge clk); #2;
    endtask

    task automatic wait_fall1(input int budget);
        int c = 0;
        while (tx1 !== 1'b0 && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= budget) check("fall_timeout", tx1, 0);
    endtask

    task automatic wait_done1(input int budget);
        int c = 0;
        while (done1 !== 1'b1 && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= budget) check("done_timeout", done1, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   seen;
        int   tidx;
        int   stop_low;
        int   c;
        bus1.din = '0; bus1.tx_start = 1'b0;
        bus2.din = '0; bus2.tx_start = 1'b0;

        // Reset: outputs at reset values even with a strobe during reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus1.din = 8'hAA; bus1.tx_start = 1'b1;
        @(posedge clk); #1;
        bus1.tx_start = 1'b0;
        check("rst_tx", tx1, 1);
        check("rst_ready", bus1.tx_ready, 1);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_state", 32'(st1), 32'(IDLE));
        check("rst_tx2", tx2, 1);
        check("rst_ready2", bus2.tx_ready, 1);
        check("rst_busy2", busy2, 0);
        @(negedge clk);
        PRESETn = 1'b1;
        tx_en   = 1'b1;

        // Single frame 0x55 with accept/launch timing
        send1(8'h55, 1'b1);
        check("acc_ready_low", bus1.tx_ready, 0);
        check("acc_tx_idle", tx1, 1);
        @(posedge clk); #1;
        check("launch_tx_low", tx1, 0);
        check("launch_ready", bus1.tx_ready, 1);
        check("launch_busy", busy1, 1);
        check("launch_state", 32'(st1), 32'(START));
        wait_idle1(2000);
        check("done_cnt_55", done_cnt, 1);

        // Back-to-back 0xA3 then 0x3C
        send1(8'hA3, 1'b1);
        repeat (20) @(posedge clk);
        send1(8'h3C, 1'b1);
        check("b2b_ready_low", bus1.tx_ready, 0);
        wait_done1(2000);
        check("b2b_no_gap", tx1, 0);
        wait_idle1(2000);
        check("done_cnt_b2b", done_cnt, 3);

        // Overflow: third strobe while the holding register is full is dropped
        send1(8'h81, 1'b1);
        repeat (20) @(posedge clk);
        send1(8'hF1, 1'b1);
        send1(8'h00, 1'b0);
        check("ovf_ready_low", bus1.tx_ready, 0);
        wait_idle1(4000);
        check("done_cnt_ovf", done_cnt, 5);

        // tx_rst in the middle of data bit 3 (bit 3 of 0xA5 is 0)
        send1(8'hA5, 1'b0);
        wait_fall1(100);
        wait_ticks(OSR + 3 * OSR + OSR / 2);
        check("pre_rst_bit3", tx1, 0);
        @(negedge clk);
        tx_rst = 1'b1; bus1.din = 8'h77; bus1.tx_start = 1'b1;
        @(posedge clk); #1;
        tx_rst = 1'b0; bus1.tx_start = 1'b0;
        check("srst_tx", tx1, 1);
        check("srst_busy", busy1, 0);
        check("srst_ready", bus1.tx_ready, 1);
        check("srst_done", done1, 0);
        seen = 0;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            if (done1 || tx1 !== 1'b1) seen = 1;
        end
        check("srst_line_quiet", seen, 0);
        check("srst_abort", abort_cnt, 1);
        check("srst_done_cnt", done_cnt, 5);

        // tx_en=0: no accept while idle; a held byte waits until tx_en returns
        @(negedge clk);
        tx_en = 1'b0;
        send1(8'h11, 1'b0);
        check("en0_no_accept", bus1.tx_ready, 1);
        @(posedge clk); #1;
        check("en0_no_start", tx1, 1);
        @(negedge clk);
        tx_en = 1'b1;
        send1(8'hC3, 1'b1);
        repeat (20) @(posedge clk);
        send1(8'h96, 1'b1);
        @(negedge clk);
        tx_en = 1'b0;
        wait_done1(2000);
        #1;
        seen = 0;
        c = 0;
        while (c < 100) begin
            @(posedge clk); #1;
            if (s_tick) c++;
            if (tx1 !== 1'b1) seen = 1;
        end
        check("en0_line_idle", seen, 0);
        check("en0_held", bus1.tx_ready, 0);
        check("en0_busy", busy1, 0);
        @(negedge clk);
        tx_en = 1'b1;
        @(posedge clk); #1;
        check("en1_start", tx1, 0);
        wait_idle1(2000);
        check("done_cnt_en", done_cnt, 7);

        // SB_TICK=32 instance: stop bit lasts 32 ticks before tx_done_tick
        @(negedge clk);
        bus2.din = 8'h3C; bus2.tx_start = 1'b1;
        @(posedge clk); #1;
        bus2.tx_start = 1'b0;
        c = 0;
        while (tx2 !== 1'b0 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        check("sb32_fall", tx2, 0);
        tidx = 0;
        stop_low = 0;
        c = 0;
        while (done2 !== 1'b1 && c < 3000) begin
            @(posedge clk); #1;
            c++;
            if (s_tick) tidx++;
            if (tidx >= OSR * (DBIT + 1) && tx2 !== 1'b1) stop_low++;
        end
        check("sb32_len", tidx, FRAME2);
        check("sb32_stop_high", stop_low, 0);
        @(posedge clk); #1;
        check("sb32_idle", busy2, 0);

        check("tx_alignment", align_err, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
